decode_operand_stage: RTL and testbench

Decode/operand-fetch pipeline stage for the RV32I core, sitting directly upstream of the `register_file` read ports and downstream of fetch. It does the following:
- Drives the register-file read addresses from the incoming instruction.
- Captures the returned operands into an ID/EX output register.
- Generates the sign-extended immediate.
- Forces x0 reads to zero.
- Bypasses same-cycle writeback data.

It moves instructions with a valid/ready handshake on both sides and supports stall and flush.

---
 rtl/decode_operand_stage.sv | 155 +++++++++++++++
 tb/tb_decode_operand_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_operand_stage.sv
// decode_operand_stage: RV32I decode / operand-fetch stage.
// Drives register-file read addresses, selects operands (x0 forced to zero,
// optional same-cycle writeback forwarding), builds the sign-extended
// immediate, flags illegal opcodes and holds everything in an ID/EX register
// with valid/ready handshakes on both sides.
// Optional feature macro: WB_BYPASS_EN. When defined, writeback data is forwarded
// into the operands. When undefined, a matching writeback stalls the input for one cycle.
module decode_operand_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [31:0]     in_pc,
  output logic [4:0]      rf_addr1,
  output logic [4:0]      rf_addr2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  input  logic            wb_we,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_pc,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic            out_funct7b5,
  output logic            out_illegal
);

  // Source indices: slot 0 is rs1, slot 1 is rs2.
  logic [1:0][4:0]      src_idx;
  logic [1:0][XLEN-1:0] rf_rd;
  logic [1:0]           bypass_hit;
  logic [1:0][XLEN-1:0] operand;
  logic [1:0][4:0]      held_idx;
  logic [1:0][XLEN-1:0] held_val;
  logic [1:0]           refresh_hit;
  logic [1:0]           stall_hit;

  logic            hazard_stall;
  logic            capture;
  logic            holding;
  logic [6:0]      opcode;
  logic [XLEN-1:0] imm;
  logic            illegal;

  assign opcode     = in_instr[6:0];
  assign src_idx[0] = in_instr[19:15];
  assign src_idx[1] = in_instr[24:20];
  assign rf_rd[0]   = rf_rd1;
  assign rf_rd[1]   = rf_rd2;
  assign rf_addr1   = src_idx[0];
  assign rf_addr2   = src_idx[1];

  // Instruction parked in the output register waiting for execute.
  assign holding = out_valid & ~out_ready;

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_operand
`ifdef WB_BYPASS_EN
    assign bypass_hit[gi] = wb_we && (wb_addr == src_idx[gi]);
    assign stall_hit[gi]  = 1'b0;
`else
    assign bypass_hit[gi] = 1'b0;
    assign stall_hit[gi]  = wb_we && (wb_addr != 5'd0) && (wb_addr == src_idx[gi]);
`endif
    // x0 wins over forwarding, forwarding wins over the register file.
    assign operand[gi] = (src_idx[gi] == 5'd0) ? '0 :
                         bypass_hit[gi]        ? wb_data : rf_rd[gi];
    // A parked operand picks up a later write to its source register.
    assign refresh_hit[gi] = holding && wb_we && (wb_addr != 5'd0) &&
                             (wb_addr == held_idx[gi]);
  end

  // Without forwarding, wait one cycle so the register file commits the write first.
  assign hazard_stall = in_valid & (|stall_hit);
  assign in_ready     = flush | ((~out_valid | out_ready) & ~hazard_stall);
  assign capture      = in_valid & in_ready & ~flush;

  // Immediate generation and illegal-opcode detection by major opcode.
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (opcode)
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011:
        imm = {{20{in_instr[31]}}, in_instr[31:20]};
      7'b0100011:
        imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      7'b1100011:
        imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
               in_instr[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm = {in_instr[31:12], 12'b0};
      7'b1101111:
        imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
               in_instr[30:21], 1'b0};
      7'b0110011, 7'b0001111:
        imm = '0;
      default: begin
        imm     = '0;
        illegal = 1'b1;
      end
    endcase
  end

  // ID/EX register: flush beats capture, capture beats drain and refresh.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_imm      <= '0;
      out_rd       <= '0;
      out_opcode   <= '0;
      out_funct3   <= '0;
      out_funct7b5 <= 1'b0;
      out_illegal  <= 1'b0;
      held_idx     <= '0;
      held_val     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_imm      <= imm;
      out_rd       <= in_instr[11:7];
      out_opcode   <= opcode;
      out_funct3   <= in_instr[14:12];
      out_funct7b5 <= in_instr[30];
      out_illegal  <= illegal;
      held_idx     <= src_idx;
      held_val     <= operand;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        if (refresh_hit[i]) begin
          held_val[i] <= wb_data;
        end
      end
    end
  end

  assign out_rs1_val = held_val[0];
  assign out_rs2_val = held_val[1];

endmodule

// File: tb/tb_decode_operand_stage.sv
// Testbench for decode_operand_stage: table-driven decode vectors plus
// hand-written sequences for reset, writeback hazard/bypass, stall with
// operand refresh and flush. Follows WB_BYPASS_EN the same way the design does.
module tb_decode_operand_stage;

  logic        clk;
  logic        clr_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rf_addr1;
  logic [4:0]  rf_addr2;
  logic [31:0] rf_rd1;
  logic [31:0] rf_rd2;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_rs1_val;
  logic [31:0] out_rs2_val;
  logic [31:0] out_imm;
  logic [4:0]  out_rd;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct7b5;
  logic        out_illegal;

  int errors = 0;
  int checks = 0;

  decode_operand_stage #(.XLEN(32)) dut (
    .clk(clk), .clr_n(clr_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
    .out_rd(out_rd), .out_opcode(out_opcode), .out_funct3(out_funct3),
    .out_funct7b5(out_funct7b5), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7b5;
    logic        ill;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'h0);
    check({tag, "_pc"},    out_pc,             32'h0);
    check({tag, "_rs1"},   out_rs1_val,        32'h0);
    check({tag, "_rs2"},   out_rs2_val,        32'h0);
    check({tag, "_imm"},   out_imm,            32'h0);
    check({tag, "_rd"},    {27'b0, out_rd},    32'h0);
    check({tag, "_op"},    {25'b0, out_opcode}, 32'h0);
  endtask

  initial begin
    //          instr         rd1           rd2           rs1           rs2           imm          rd     op        f3    f7 ill
    vecs[0]  = '{32'h00500093, 32'h0000DEAD, 32'h00000077, 32'h00000000, 32'h00000077, 32'h00000005, 5'd1,  7'h13, 3'd0, 1'b0, 1'b0}; // addi x1,x0,5
    vecs[1]  = '{32'h002081B3, 32'h00000011, 32'h00000022, 32'h00000011, 32'h00000022, 32'h00000000, 5'd3,  7'h33, 3'd0, 1'b0, 1'b0}; // add x3,x1,x2
    vecs[2]  = '{32'h407302B3, 32'h00000066, 32'h00000077, 32'h00000066, 32'h00000077, 32'h00000000, 5'd5,  7'h33, 3'd0, 1'b1, 1'b0}; // sub x5,x6,x7
    vecs[3]  = '{32'hFE000EE3, 32'h00000123, 32'h00000456, 32'h00000000, 32'h00000000, 32'hFFFFFFFC, 5'd29, 7'h63, 3'd0, 1'b1, 1'b0}; // beq x0,x0,-4
    vecs[4]  = '{32'h12345600, 32'h0000000A, 32'h0000000B, 32'h0000000A, 32'h0000000B, 32'h00000000, 5'd12, 7'h00, 3'd5, 1'b0, 1'b1}; // illegal opcode 0
    vecs[5]  = '{32'hABCDE537, 32'h00000100, 32'h00000200, 32'h00000100, 32'h00000200, 32'hABCDE000, 5'd10, 7'h37, 3'd6, 1'b0, 1'b0}; // lui x10
    vecs[6]  = '{32'hFE20AC23, 32'h00001000, 32'h00002000, 32'h00001000, 32'h00002000, 32'hFFFFFFF8, 5'd24, 7'h23, 3'd2, 1'b1, 1'b0}; // sw x2,-8(x1)
    vecs[7]  = '{32'h001000EF, 32'h00000005, 32'h00000006, 32'h00000000, 32'h00000006, 32'h00000800, 5'd1,  7'h6F, 3'd0, 1'b0, 1'b0}; // jal x1,+2048
    vecs[8]  = '{32'h80000397, 32'h00000031, 32'h00000032, 32'h00000000, 32'h00000000, 32'h80000000, 5'd7,  7'h17, 3'd0, 1'b0, 1'b0}; // auipc x7
    vecs[9]  = '{32'hFFF2A203, 32'h00000033, 32'h00000044, 32'h00000033, 32'h00000044, 32'hFFFFFFFF, 5'd4,  7'h03, 3'd2, 1'b1, 1'b0}; // lw x4,-1(x5)
    vecs[10] = '{32'h0000000F, 32'h00000055, 32'h00000066, 32'h00000000, 32'h00000000, 32'h00000000, 5'd0,  7'h0F, 3'd0, 1'b0, 1'b0}; // fence

    clr_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    rf_rd1 = '0; rf_rd2 = '0; wb_we = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;

    // Reset state before any clock edge.
    #3;
    check_zero_outputs("reset_init");
    $display("reset: initial state checked");
    @(negedge clk);
    clr_n = 1'b1;

    // Table-driven stream at full throughput with out_ready held high.
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_pc    = 32'h100 + 32'(i) * 4;
      rf_rd1   = vecs[i].rd1;
      rf_rd2   = vecs[i].rd2;
      #1;
      check($sformatf("v%0d_ready", i), {31'b0, in_ready}, 32'h1);
      check($sformatf("v%0d_addr1", i), {27'b0, rf_addr1}, {27'b0, vecs[i].instr[19:15]});
      check($sformatf("v%0d_addr2", i), {27'b0, rf_addr2}, {27'b0, vecs[i].instr[24:20]});
      @(negedge clk);
      check($sformatf("v%0d_valid", i), {31'b0, out_valid}, 32'h1);
      check($sformatf("v%0d_pc", i), out_pc, 32'h100 + 32'(i) * 4);
      check($sformatf("v%0d_rs1", i), out_rs1_val, vecs[i].rs1);
      check($sformatf("v%0d_rs2", i), out_rs2_val, vecs[i].rs2);
      check($sformatf("v%0d_imm", i), out_imm, vecs[i].imm);
      check($sformatf("v%0d_rd", i), {27'b0, out_rd}, {27'b0, vecs[i].rd});
      check($sformatf("v%0d_op", i), {25'b0, out_opcode}, {25'b0, vecs[i].op});
      check($sformatf("v%0d_f3", i), {29'b0, out_funct3}, {29'b0, vecs[i].f3});
      check($sformatf("v%0d_f7b5", i), {31'b0, out_funct7b5}, {31'b0, vecs[i].f7b5});
      check($sformatf("v%0d_ill", i), {31'b0, out_illegal}, {31'b0, vecs[i].ill});
      $display("vec %0d: instr=%h imm=%h rs1=%h rs2=%h ill=%0d",
               i, vecs[i].instr, out_imm, out_rs1_val, out_rs2_val, out_illegal);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("drain_valid", {31'b0, out_valid}, 32'h0);

    // Writeback to x1 in the same cycle as add x3,x1,x2.
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h200;
    rf_rd1 = 32'h0; rf_rd2 = 32'h22;
    wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'h1234;
    #1;
`ifdef WB_BYPASS_EN
    check("byp_ready", {31'b0, in_ready}, 32'h1);
    @(negedge clk);
    wb_we = 1'b0;
`else
    check("haz_ready", {31'b0, in_ready}, 32'h0);
    @(negedge clk);
    check("haz_valid", {31'b0, out_valid}, 32'h0);
    wb_we = 1'b0; rf_rd1 = 32'h1234;
    #1;
    check("haz_ready2", {31'b0, in_ready}, 32'h1);
    @(negedge clk);
`endif
    check("byp_valid", {31'b0, out_valid}, 32'h1);
    check("byp_rs1", out_rs1_val, 32'h1234);
    check("byp_rs2", out_rs2_val, 32'h22);
    $display("bypass: rs1=%h rs2=%h", out_rs1_val, out_rs2_val);

    // Stall with the add parked; a write to x2 refreshes rs2.
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00000013; in_pc = 32'h204;
    rf_rd1 = 32'h99; rf_rd2 = 32'h99;
    wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'h55;
    #1;
    check("stall_ready", {31'b0, in_ready}, 32'h0);
    @(negedge clk);
    wb_we = 1'b0;
    check("refresh_rs2", out_rs2_val, 32'h55);
    check("refresh_rs1", out_rs1_val, 32'h1234);
    check("stall_valid", {31'b0, out_valid}, 32'h1);
    #1;
    check("stall_ready2", {31'b0, in_ready}, 32'h0);
    @(negedge clk);
    check("stall_op", {25'b0, out_opcode}, 32'h33);
    check("stall_pc", out_pc, 32'h200);
    out_ready = 1'b1;
    #1;
    check("unstall_ready", {31'b0, in_ready}, 32'h1);
    @(negedge clk);
    check("b2b_valid", {31'b0, out_valid}, 32'h1);
    check("b2b_op", {25'b0, out_opcode}, 32'h13);
    check("b2b_pc", out_pc, 32'h204);
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_drain", {31'b0, out_valid}, 32'h0);
    $display("stall/refresh: sequence done");

    // Flush with a held instruction and a new input beat.
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h500;
    @(negedge clk);
    check("fl_hold_valid", {31'b0, out_valid}, 32'h1);
    flush = 1'b1; in_instr = 32'h407302B3; in_pc = 32'h600;
    #1;
    check("fl_ready", {31'b0, in_ready}, 32'h1);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid", {31'b0, out_valid}, 32'h0);
    check("fl_pc", out_pc, 32'h500);
    @(negedge clk);
    check("fl_valid2", {31'b0, out_valid}, 32'h0);
    $display("flush: sequence done");

    // Asynchronous reset while an instruction is held.
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h700;
    rf_rd1 = 32'hDEAD; rf_rd2 = 32'h77;
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_pre_valid", {31'b0, out_valid}, 32'h1);
    #2;
    clr_n = 1'b0;
    #1;
    check_zero_outputs("reset_async");
    $display("reset: asynchronous clear checked");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
